muldiv_seq: RTL



---
 rtl/muldiv_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer.
// It drives the shared pipeline ALU and uses its Result; it has no adder of its own.
module muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] alu_srca,
  output logic [XLEN-1:0] alu_srcb,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [1:0]        op_reg;
  logic [XLEN-1:0]   hi, lo, mcand;
  logic [XLEN-1:0]   rem, q, div;

  logic [XLEN-1:0]   t;
  logic              carry, take;
  logic [XLEN-1:0]   hi_next, lo_next, rem_next, q_next, final_val;

  assign busy = (state != IDLE);
  assign t    = {rem[XLEN-2:0], q[XLEN-1]};

  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_ctrl = 3'b000;
    if (state == RUN) begin
      if (op_reg[1]) begin
        alu_srca = t;
        alu_srcb = div;
        alu_ctrl = 3'b001;
      end else begin
        alu_srca = hi;
        alu_srcb = mcand;
      end
    end
  end

  // Shift-add step: the ALU carry-out is recovered by the unsigned wrap test.
  always_comb begin
    carry = (alu_result < hi);
    if (lo[0]) begin
      hi_next = {carry, alu_result[XLEN-1:1]};
      lo_next = {alu_result[0], lo[XLEN-1:1]};
    end else begin
      hi_next = {1'b0, hi[XLEN-1:1]};
      lo_next = {hi[0], lo[XLEN-1:1]};
    end
  end

  // Restoring step: a set rem[31] means the shifted partial remainder exceeds any divisor.
  always_comb begin
    take     = rem[XLEN-1] | (t >= div);
    rem_next = take ? alu_result : t;
    q_next   = {q[XLEN-2:0], take};
  end

  always_comb begin
    if (op_reg[1]) final_val = op_reg[0] ? rem_next : q_next;
    else           final_val = op_reg[0] ? hi_next  : lo_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      op_reg <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      rem    <= '0;
      q      <= '0;
      div    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_reg <= op;
            count  <= '0;
            if (op[1] && (opb == '0)) begin
              result <= op[0] ? opa : '1;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              hi    <= '0;
              lo    <= opb;
              mcand <= opa;
              rem   <= '0;
              q     <= opa;
              div   <= opb;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (op_reg[1]) begin
            rem <= rem_next;
            q   <= q_next;
          end else begin
            hi <= hi_next;
            lo <= lo_next;
          end
          count <= count + 1'b1;
          if (count == CW'(ITER - 1)) begin
            result <= final_val;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
